// File: rtl/cv_countbit_pkg.sv
// ---------------------------------------------------------------------------
// cv_countbit_pkg
//
// Shared definitions for the cv_countbit family:
//   - clog2()       : constant ceil(log2(value)) helper
//   - cwidth()      : width needed to hold a popcount of an ISIZE-bit word
//                     (CWIDTH = clog2(ISIZE+1))
//   - *_DEF         : default widths used by the streaming counter
// ---------------------------------------------------------------------------
package cv_countbit_pkg;

    localparam int ISIZE_DEF = 32;   // input word width
    localparam int OSIZE_DEF = 16;   // accumulated count width
    localparam int BSIZE_DEF = 12;   // beat counter width

    // ceil(log2(value)); returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Bits needed to represent 0..isize inclusive.
    function automatic int cwidth(input int isize);
        return clog2(isize + 1);
    endfunction

endpackage

// File: rtl/cv_countbit.sv
// ---------------------------------------------------------------------------
// cv_countbit
//
// Combinational bit counter: counts how many bits of data_i equal CBIT.
//
// Parameters:
//   ISIZE  : input word width
//   CWIDTH : result width (must hold 0..ISIZE)
//   CBIT   : bit value being counted
//
// Ports:
//   data_i  [ISIZE-1:0]  input word
//   count_o [CWIDTH-1:0] number of bits of data_i equal to CBIT
// ---------------------------------------------------------------------------
module cv_countbit
    import cv_countbit_pkg::*;
#(
    parameter int ISIZE  = ISIZE_DEF,
    parameter int CWIDTH = cwidth(ISIZE),
    parameter bit CBIT   = 1'b1
) (
    input  logic [ISIZE-1:0]  data_i,
    output logic [CWIDTH-1:0] count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < ISIZE; i++) begin
            if (data_i[i] == CBIT) begin
                count_o = count_o + CWIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/cv_countbit_stream.sv
// ---------------------------------------------------------------------------
// cv_countbit_stream
//
// Two-stage streaming bit counter. Each accepted beat of a frame contributes
// the number of its bits equal to the selected bit value; one total per
// frame is delivered on the m_* interface.
//
//   stage 1 : registers the per-beat popcount, the last flag and a valid bit
//   stage 2 : accumulates counts and beats; on the last beat it loads the
//             result registers and clears the accumulator in the same cycle
//
// Handshake (both sides): a transfer happens on a rising clock edge where
// valid and ready are both high. Once m_valid is high, m_valid and all m_*
// fields stay stable until the edge where m_ready is also high. s_ready only
// falls when stage 1 holds a last beat that cannot drain because an older
// result is still waiting to be consumed.
//
// Configuration macro:
//   CV_COUNTBIT_SAT_EN : defined   -> accumulator saturates at 2^OSIZE-1
//                        undefined -> accumulator wraps modulo 2^OSIZE
//   In both builds m_ovf reports that the true sum exceeded 2^OSIZE-1.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cbit_ovr, cbit_sel  runtime override of the counted bit value
//   s_valid/s_ready     input beat handshake
//   s_data [ISIZE-1:0]  input word, s_last marks the final beat of a frame
//   m_valid/m_ready     result handshake
//   m_count [OSIZE-1:0] matching-bit total of the frame
//   m_beats [BSIZE-1:0] beats in the frame (wraps modulo 2^BSIZE)
//   m_ovf               accumulator exceeded 2^OSIZE-1 during the frame
// ---------------------------------------------------------------------------
module cv_countbit_stream
    import cv_countbit_pkg::*;
#(
    parameter int ISIZE    = ISIZE_DEF,
    parameter int OSIZE    = OSIZE_DEF,
    parameter int BSIZE    = BSIZE_DEF,
    parameter bit CBIT_DEF = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cbit_ovr,
    input  logic             cbit_sel,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [ISIZE-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OSIZE-1:0] m_count,
    output logic [BSIZE-1:0] m_beats,
    output logic             m_ovf
);

    localparam int CWIDTH = clog2(ISIZE + 1);

    // -----------------------------------------------------------------------
    // Stage 0: bit selection and combinational popcount
    // -----------------------------------------------------------------------
    logic              cbit;
    logic [ISIZE-1:0]  data_x;
    logic [CWIDTH-1:0] beat_cnt;

    assign cbit = cbit_ovr ? cbit_sel : CBIT_DEF;

    // The counter always counts ones; inverting the word when counting zeros
    // gives popcount(s_data XNOR {ISIZE{cbit}}).
    assign data_x = s_data ^ {ISIZE{~cbit}};

    cv_countbit #(
        .ISIZE  (ISIZE),
        .CWIDTH (CWIDTH),
        .CBIT   (1'b1)
    ) u_count (
        .data_i  (data_x),
        .count_o (beat_cnt)
    );

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic             s1_v_q,     s1_v_d;
    logic             s1_last_q,  s1_last_d;
    logic [OSIZE-1:0] s1_cnt_q,   s1_cnt_d;

    logic [OSIZE-1:0] acc_q,      acc_d;
    logic [BSIZE-1:0] beats_q,    beats_d;
    logic             ovf_q,      ovf_d;

    logic             m_valid_q,  m_valid_d;
    logic [OSIZE-1:0] m_count_q,  m_count_d;
    logic [BSIZE-1:0] m_beats_q,  m_beats_d;
    logic             m_ovf_q,    m_ovf_d;

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    logic stall;
    logic s_fire;
    logic s1_adv;

    // Only a last beat can be blocked: it needs the result registers, which
    // are busy while an unconsumed result sits there.
    assign stall   = s1_v_q & s1_last_q & m_valid_q & ~m_ready;
    assign s_ready = ~s1_v_q | ~stall;
    assign s_fire  = s_valid & s_ready;
    assign s1_adv  = s1_v_q & ~stall;

    // -----------------------------------------------------------------------
    // Accumulator arithmetic (OSIZE+1 bits so the carry is visible)
    // -----------------------------------------------------------------------
    logic [OSIZE:0]   sum;
    logic             carry;
    logic [OSIZE-1:0] acc_next;
    logic [BSIZE-1:0] beats_next;

    assign sum        = {1'b0, acc_q} + {1'b0, s1_cnt_q};
    assign carry      = sum[OSIZE];
    assign beats_next = beats_q + BSIZE'(1);

`ifdef CV_COUNTBIT_SAT_EN
    // Once clamped the accumulator stays at all-ones for the rest of the
    // frame; further additions either carry again or add zero.
    assign acc_next = carry ? {OSIZE{1'b1}} : sum[OSIZE-1:0];
`else
    assign acc_next = sum[OSIZE-1:0];
`endif

    // -----------------------------------------------------------------------
    // Stage 1 next state
    // -----------------------------------------------------------------------
    always_comb begin
        s1_v_d    = s1_v_q;
        s1_last_d = s1_last_q;
        s1_cnt_d  = s1_cnt_q;
        if (s_fire) begin
            s1_v_d    = 1'b1;
            s1_last_d = s_last;
            s1_cnt_d  = OSIZE'(beat_cnt);
        end else if (s1_adv) begin
            s1_v_d    = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2 next state
    // -----------------------------------------------------------------------
    always_comb begin
        acc_d     = acc_q;
        beats_d   = beats_q;
        ovf_d     = ovf_q;
        m_valid_d = m_valid_q;
        m_count_d = m_count_q;
        m_beats_d = m_beats_q;
        m_ovf_d   = m_ovf_q;

        if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end

        if (s1_adv) begin
            if (s1_last_q) begin
                // Close the frame: publish totals and start the next frame
                // from zero in the same cycle. This also covers the case
                // where the previous result is consumed on this edge.
                m_valid_d = 1'b1;
                m_count_d = acc_next;
                m_beats_d = beats_next;
                m_ovf_d   = ovf_q | carry;
                acc_d     = '0;
                beats_d   = '0;
                ovf_d     = 1'b0;
            end else begin
                acc_d     = acc_next;
                beats_d   = beats_next;
                ovf_d     = ovf_q | carry;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_v_q    <= 1'b0;
            s1_last_q <= 1'b0;
            s1_cnt_q  <= '0;
            acc_q     <= '0;
            beats_q   <= '0;
            ovf_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_count_q <= '0;
            m_beats_q <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            s1_v_q    <= s1_v_d;
            s1_last_q <= s1_last_d;
            s1_cnt_q  <= s1_cnt_d;
            acc_q     <= acc_d;
            beats_q   <= beats_d;
            ovf_q     <= ovf_d;
            m_valid_q <= m_valid_d;
            m_count_q <= m_count_d;
            m_beats_q <= m_beats_d;
            m_ovf_q   <= m_ovf_d;
        end
    end

    assign m_valid = m_valid_q;
    assign m_count = m_count_q;
    assign m_beats = m_beats_q;
    assign m_ovf   = m_ovf_q;

endmodule

// File: tb/tb_cv_countbit_stream.sv
module tb_cv_countbit_stream;

    localparam int ISIZE  = 32;
    localparam int OSIZE  = 16;
    localparam int BSIZE  = 12;
    localparam int OSIZE2 = 6;
    localparam int EW     = 1 + BSIZE + OSIZE;
    localparam int NFRAMES = 300;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- main instance (OSIZE=16) ----------------
    logic             cbit_ovr, cbit_sel;
    logic             s_valid, s_ready, s_last;
    logic [ISIZE-1:0] s_data;
    logic             m_valid, m_ready, m_ovf;
    logic [OSIZE-1:0] m_count;
    logic [BSIZE-1:0] m_beats;

    cv_countbit_stream #(
        .ISIZE(ISIZE), .OSIZE(OSIZE), .BSIZE(BSIZE), .CBIT_DEF(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cbit_ovr(cbit_ovr), .cbit_sel(cbit_sel),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_count(m_count),
        .m_beats(m_beats), .m_ovf(m_ovf)
    );

    // ---------------- narrow instance (OSIZE=6) ----------------
    logic              v_cbit_ovr, v_cbit_sel;
    logic              v_s_valid, v_s_ready, v_s_last;
    logic [ISIZE-1:0]  v_s_data;
    logic              v_m_valid, v_m_ready, v_m_ovf;
    logic [OSIZE2-1:0] v_m_count;
    logic [BSIZE-1:0]  v_m_beats;

    cv_countbit_stream #(
        .ISIZE(ISIZE), .OSIZE(OSIZE2), .BSIZE(BSIZE), .CBIT_DEF(1'b1)
    ) dut_narrow (
        .clk(clk), .rst_n(rst_n), .cbit_ovr(v_cbit_ovr), .cbit_sel(v_cbit_sel),
        .s_valid(v_s_valid), .s_ready(v_s_ready), .s_data(v_s_data), .s_last(v_s_last),
        .m_valid(v_m_valid), .m_ready(v_m_ready), .m_count(v_m_count),
        .m_beats(v_m_beats), .m_ovf(v_m_ovf)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q[$];

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic send_beat(input logic [ISIZE-1:0] d, input logic last,
                             input logic ovr, input logic sel);
        int  w;
        bit  rdy;
        s_valid  = 1'b1;
        s_data   = d;
        s_last   = last;
        cbit_ovr = ovr;
        cbit_sel = sel;
        w = 0;
        do begin
            rdy = s_ready;
            @(posedge clk); #1;
            w++;
        end while (!rdy && w < 50);
        s_valid = 1'b0;
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL send_beat_timeout: s_ready=%b after %0d cycles, required 1", rdy, w);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({s_ready, m_valid, m_ovf, m_beats, m_count} !== {1'b1, 1'b0, 1'b0, 12'd0, 16'd0}) begin
            errors++;
            $display("FAIL reset_outputs: s_ready=%b m_valid=%b m_ovf=%b m_beats=%0d m_count=%0d, required 1 0 0 0 0",
                     s_ready, m_valid, m_ovf, m_beats, m_count);
        end
        checks++;
        if ({v_s_ready, v_m_valid, v_m_ovf, v_m_count} !== {1'b1, 1'b0, 1'b0, 6'd0}) begin
            errors++;
            $display("FAIL reset_narrow: s_ready=%b m_valid=%b m_ovf=%b m_count=%0d, required 1 0 0 0",
                     v_s_ready, v_m_valid, v_m_ovf, v_m_count);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_beat;
        send_beat(32'hF0F0_F0F1, 1'b1, 1'b0, 1'b0);
        // cycle L+1: result not yet visible
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency_early: m_valid=%b at L+1, required 0", m_valid);
        end
        @(posedge clk); #1;
        checks++;
        if ({m_valid, m_ovf, m_beats, m_count} !== {1'b1, 1'b0, 12'd1, 16'd17}) begin
            errors++;
            $display("FAIL single_result: valid=%b ovf=%b beats=%0d count=%0d, required 1 0 1 17",
                     m_valid, m_ovf, m_beats, m_count);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_consume: m_valid=%b after handshake, required 0", m_valid);
        end
    endtask

    task automatic test_multi_beat;
        // Counting zeros via override: 0 + 32 + 31
        send_beat(32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0);
        send_beat(32'h0000_0000, 1'b0, 1'b1, 1'b0);
        send_beat(32'h0000_0001, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({m_valid, m_ovf, m_beats, m_count} !== {1'b1, 1'b0, 12'd3, 16'd63}) begin
            errors++;
            $display("FAIL multi_result: valid=%b ovf=%b beats=%0d count=%0d, required 1 0 3 63",
                     m_valid, m_ovf, m_beats, m_count);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        m_ready = 1'b0;
        // Frame A: 0x000000FF counting zeros -> 24
        send_beat(32'h0000_00FF, 1'b1, 1'b1, 1'b0);
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_early: s_ready=%b with no pending result, required 1", s_ready);
        end
        // Frame B: 0x0FFFFFFF counting ones -> 28
        send_beat(32'h0FFF_FFFF, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s_ready, m_valid, m_beats, m_count} !== {1'b0, 1'b1, 12'd1, 16'd24}) begin
                errors++;
                $display("FAIL b2b_hold_%0d: s_ready=%b valid=%b beats=%0d count=%0d, required 0 1 1 24",
                         i, s_ready, m_valid, m_beats, m_count);
            end
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({s_ready, m_valid, m_ovf, m_beats, m_count} !== {1'b1, 1'b1, 1'b0, 12'd1, 16'd28}) begin
            errors++;
            $display("FAIL b2b_second: s_ready=%b valid=%b ovf=%b beats=%0d count=%0d, required 1 1 0 1 28",
                     s_ready, m_valid, m_ovf, m_beats, m_count);
        end
        @(posedge clk); #1;
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: m_valid=%b, required 0", m_valid);
        end
        m_ready = 1'b0;
    endtask

    task automatic test_overflow;
        logic [OSIZE2-1:0] exp_cnt;
`ifdef CV_COUNTBIT_SAT_EN
        exp_cnt = 6'd63;
`else
        exp_cnt = 6'd32;
`endif
        v_s_valid = 1'b1;
        v_s_data  = 32'hFFFF_FFFF;
        v_s_last  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        v_s_last  = 1'b1;
        @(posedge clk); #1;
        v_s_valid = 1'b0;
        v_s_last  = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({v_m_valid, v_m_ovf, v_m_beats, v_m_count} !== {1'b1, 1'b1, 12'd3, exp_cnt}) begin
            errors++;
            $display("FAIL overflow_result: valid=%b ovf=%b beats=%0d count=%0d, required 1 1 3 %0d",
                     v_m_valid, v_m_ovf, v_m_beats, v_m_count, exp_cnt);
        end
        v_m_ready = 1'b1;
        // Next frame must start with a cleared sticky flag: 0xF -> 4
        v_s_valid = 1'b1;
        v_s_data  = 32'h0000_000F;
        v_s_last  = 1'b1;
        @(posedge clk); #1;
        v_s_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({v_m_valid, v_m_ovf, v_m_beats, v_m_count} !== {1'b1, 1'b0, 12'd1, 6'd4}) begin
            errors++;
            $display("FAIL overflow_cleared: valid=%b ovf=%b beats=%0d count=%0d, required 1 0 1 4",
                     v_m_valid, v_m_ovf, v_m_beats, v_m_count);
        end
        @(posedge clk); #1;
        v_m_ready = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        send_beat(32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        send_beat(32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if ({s_ready, m_valid, m_ovf, m_beats, m_count} !== {1'b1, 1'b0, 1'b0, 12'd0, 16'd0}) begin
            errors++;
            $display("FAIL midreset_outputs: s_ready=%b valid=%b ovf=%b beats=%0d count=%0d, required 1 0 0 0 0",
                     s_ready, m_valid, m_ovf, m_beats, m_count);
        end
        send_beat(32'h0000_0003, 1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        checks++;
        if ({m_valid, m_ovf, m_beats, m_count} !== {1'b1, 1'b0, 12'd1, 16'd2}) begin
            errors++;
            $display("FAIL midreset_frame: valid=%b ovf=%b beats=%0d count=%0d, required 1 0 1 2",
                     m_valid, m_ovf, m_beats, m_count);
        end
        m_ready = 1'b1;
        @(posedge clk); #1;
        m_ready = 1'b0;
    endtask

    task automatic test_random_stream;
        // producer state
        int          nb, pc, w, gap;
        logic [16:0] acc;
        logic        ovf, ovr, sel, cb, rdy;
        logic [31:0] d;
        // consumer state
        int          got, cyc;
        bit          hold;
        logic [EW-1:0] held, e;

        exp_q.delete();
        got  = 0;
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        fork
            begin : producer
                #1;
                for (int f = 0; f < NFRAMES; f++) begin
                    nb  = $urandom_range(1, 6);
                    acc = '0;
                    ovf = 1'b0;
                    for (int b = 0; b < nb; b++) begin
                        gap = $urandom_range(0, 2);
                        s_valid = 1'b0;
                        repeat (gap) begin @(posedge clk); #2; end
                        d   = $urandom;
                        ovr = 1'($urandom_range(0, 1));
                        sel = 1'($urandom_range(0, 1));
                        cb  = ovr ? sel : 1'b1;
                        pc  = 0;
                        for (int i = 0; i < ISIZE; i++) if (d[i] == cb) pc++;
                        acc = acc + 17'(pc);
                        if (acc > 17'd65535) begin
                            ovf = 1'b1;
`ifdef CV_COUNTBIT_SAT_EN
                            acc = 17'd65535;
`else
                            acc = acc - 17'd65536;
`endif
                        end
                        s_valid  = 1'b1;
                        s_data   = d;
                        s_last   = (b == nb - 1);
                        cbit_ovr = ovr;
                        cbit_sel = sel;
                        if (b == nb - 1) exp_q.push_back({ovf, 12'(nb), acc[15:0]});
                        w = 0;
                        do begin
                            rdy = s_ready;
                            @(posedge clk); #2;
                            w++;
                        end while (!rdy && w < 200);
                        if (!rdy) begin
                            checks++;
                            errors++;
                            $display("FAIL random_input_timeout: frame %0d beat %0d s_ready stuck at 0", f, b);
                        end
                    end
                end
                s_valid = 1'b0;
                s_last  = 1'b0;
            end
            begin : consumer
                while (got < NFRAMES && cyc < 20000) begin
                    if (hold) begin
                        checks++;
                        if ({m_valid, m_ovf, m_beats, m_count} !== {1'b1, held}) begin
                            errors++;
                            $display("FAIL random_stable: valid=%b ovf=%b beats=%0d count=%0d, required 1 %b %0d %0d",
                                     m_valid, m_ovf, m_beats, m_count, held[EW-1], held[EW-2:OSIZE], held[OSIZE-1:0]);
                        end
                    end
                    m_ready = ($urandom_range(0, 3) != 0);
                    if (m_valid && m_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL random_unexpected: result count=%0d beats=%0d with empty queue", m_count, m_beats);
                        end else begin
                            e = exp_q.pop_front();
                            if ({m_ovf, m_beats, m_count} !== e) begin
                                errors++;
                                $display("FAIL random_result_%0d: ovf=%b beats=%0d count=%0d, required %b %0d %0d",
                                         got, m_ovf, m_beats, m_count, e[EW-1], e[EW-2:OSIZE], e[OSIZE-1:0]);
                            end
                        end
                        got++;
                    end
                    hold = m_valid && !m_ready;
                    held = {m_ovf, m_beats, m_count};
                    @(posedge clk); #1;
                    cyc++;
                end
                m_ready = 1'b0;
                checks++;
                if (got != NFRAMES) begin
                    errors++;
                    $display("FAIL random_frames: received %0d, required %0d", got, NFRAMES);
                end
            end
        join
        @(posedge clk); #1;
    endtask

    // ---------------- sequence & report ----------------
    initial begin
        rst_n      = 1'b0;
        cbit_ovr   = 1'b0;
        cbit_sel   = 1'b0;
        s_valid    = 1'b0;
        s_data     = '0;
        s_last     = 1'b0;
        m_ready    = 1'b0;
        v_cbit_ovr = 1'b0;
        v_cbit_sel = 1'b0;
        v_s_valid  = 1'b0;
        v_s_data   = '0;
        v_s_last   = 1'b0;
        v_m_ready  = 1'b0;

        test_reset();
        test_single_beat();
        test_multi_beat();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_random_stream();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
